// File: rtl/frame_pingpong_buffer_if.sv
// Bus bundle for the ping-pong frame store: writer port, reader port and
// bank/status outputs. The master side drives strobes, the slave side is the store.
interface frame_pingpong_buffer_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 15,
    parameter int DROP_W = 8
);
    // Writer side
    logic              w_en;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] d_in;
    logic              w_eof;

    // Reader side
    logic              r_en;
    logic [ADDR_W-1:0] r_addr;
    logic              r_lock;
    logic [DATA_W-1:0] d_out;
    logic              r_valid;

    // Bank status
    logic              frame_valid;
    logic              w_bank;
    logic              r_bank;
    logic              swap;
    logic              err_w;
    logic [DROP_W-1:0] drop_cnt;

    modport master (
        output w_en, w_addr, d_in, w_eof, r_en, r_addr, r_lock,
        input  d_out, r_valid, frame_valid, w_bank, r_bank, swap, err_w, drop_cnt
    );

    modport slave (
        input  w_en, w_addr, d_in, w_eof, r_en, r_addr, r_lock,
        output d_out, r_valid, frame_valid, w_bank, r_bank, swap, err_w, drop_cnt
    );
endinterface

// File: rtl/frame_pingpong_buffer.sv
// Double-buffered frame store. The writer fills w_bank while the reader scans
// the completed r_bank; banks swap at writer end-of-frame unless the reader
// holds r_lock, in which case the swap waits and further frames are dropped.
module frame_pingpong_buffer #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 15,
    parameter int DROP_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    frame_pingpong_buffer_if.slave bus
);
    localparam int               DEPTH    = 1 << ADDR_W;
    localparam logic [DROP_W-1:0] DROP_MAX = '1;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,  // no completed frame yet
        ST_SHOW    = 2'd1,  // read bank complete, writer filling the other
        ST_PENDING = 2'd2   // write bank complete, swap deferred by r_lock
    } state_t;

    state_t            state, state_nxt;
    logic              w_bank_q;
    logic              do_swap;
    logic              drop_inc;
    logic              wr_accept;

    // Bank storage, physical address {bank, addr}
    logic [DATA_W-1:0] mem [0:2*DEPTH-1];

    // Next-state, swap and drop decisions from the state sampled at this edge
    // NOTE: every output of this block is given a default first so no path
    // leaves a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        do_swap   = 1'b0;
        drop_inc  = 1'b0;
        unique case (state)
            ST_EMPTY, ST_SHOW: begin
                if (bus.w_eof) begin
                    if (bus.r_lock) begin
                        state_nxt = ST_PENDING;
                    end else begin
                        do_swap   = 1'b1;
                        state_nxt = ST_SHOW;
                    end
                end
            end
            ST_PENDING: begin
                // A frame closed while the finished one still waits is lost
                drop_inc = bus.w_eof;
                if (!bus.r_lock) begin
                    do_swap   = 1'b1;
                    state_nxt = ST_SHOW;
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
    end

    // Writes are only accepted while the write bank is still open
    assign wr_accept = bus.w_en && (state != ST_PENDING);

    // State, bank select and status flags
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= ST_EMPTY;
            w_bank_q        <= 1'b0;
            bus.swap        <= 1'b0;
            bus.err_w       <= 1'b0;
            bus.frame_valid <= 1'b0;
            bus.drop_cnt    <= '0;
        end else begin
            state           <= state_nxt;
            bus.swap        <= do_swap;
            bus.err_w       <= bus.w_en && (state == ST_PENDING);
            bus.frame_valid <= (state_nxt != ST_EMPTY);
            if (do_swap) begin
                w_bank_q <= ~w_bank_q;
            end
            if (drop_inc && (bus.drop_cnt != DROP_MAX)) begin
                bus.drop_cnt <= bus.drop_cnt + 1'b1;
            end
        end
    end

    // Memory write into the current write bank
    // NOTE: the array has no reset; contents are undefined after reset and
    // clearing it would defeat block-RAM mapping.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[{w_bank_q, bus.w_addr}] <= bus.d_in;
        end
    end

    // Registered read from the bank the reader owned before this edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.d_out   <= '0;
            bus.r_valid <= 1'b0;
        end else begin
            bus.r_valid <= bus.r_en;
            if (bus.r_en) begin
                bus.d_out <= mem[{~w_bank_q, bus.r_addr}];
            end
        end
    end

    assign bus.w_bank = w_bank_q;
    assign bus.r_bank = ~w_bank_q;

endmodule

// File: tb/tb_frame_pingpong_buffer.sv
// Directed bench for frame_pingpong_buffer: read data is checked by a
// scoreboard queue popped by an independent monitor; status outputs are
// checked directly after each edge.
module tb_frame_pingpong_buffer;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 15;
    localparam int DROP_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    logic [DATA_W-1:0] exp_q [$];

    frame_pingpong_buffer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DROP_W(DROP_W)) bus ();

    frame_pingpong_buffer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DROP_W(DROP_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: pops one expected word for every valid read beat
    always @(negedge clk) begin
        if (!rst && bus.r_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL read_unexpected: got 0x%0h expected no read beat", bus.d_out);
            end else begin
                logic [DATA_W-1:0] e;
                e = exp_q.pop_front();
                if (bus.d_out !== e) begin
                    failures++;
                    $display("FAIL read_data: got 0x%0h expected 0x%0h", bus.d_out, e);
                end
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.w_en   = 1'b0;
        bus.w_eof  = 1'b0;
        bus.r_en   = 1'b0;
        bus.w_addr = '0;
        bus.d_in   = '0;
        bus.r_addr = '0;
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        bus.w_en = 1'b1; bus.w_addr = a; bus.d_in = d;
        tick();
        bus.w_en = 1'b0;
    endtask

    task automatic rd(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] e);
        bus.r_en = 1'b1; bus.r_addr = a;
        exp_q.push_back(e);
        tick();
        bus.r_en = 1'b0;
    endtask

    task automatic eof();
        bus.w_eof = 1'b1;
        tick();
        bus.w_eof = 1'b0;
    endtask

    initial begin
        bus.r_lock = 1'b0;
        idle_inputs();
        repeat (2) tick();
        rst = 1'b0;
        tick();

        // Reset values
        check("rst_frame_valid", 32'(bus.frame_valid), 0);
        check("rst_w_bank",      32'(bus.w_bank), 0);
        check("rst_r_bank",      32'(bus.r_bank), 1);
        check("rst_swap",        32'(bus.swap), 0);
        check("rst_err_w",       32'(bus.err_w), 0);
        check("rst_drop_cnt",    32'(bus.drop_cnt), 0);
        check("rst_d_out",       32'(bus.d_out), 0);

        // First frame: write bank 0, close it, read it back
        wr(15'd5, 16'hAAAA);
        check("show_err_w", 32'(bus.err_w), 0);
        eof();
        check("eof1_swap",        32'(bus.swap), 1);
        check("eof1_w_bank",      32'(bus.w_bank), 1);
        check("eof1_r_bank",      32'(bus.r_bank), 0);
        check("eof1_frame_valid", 32'(bus.frame_valid), 1);
        tick();
        check("swap_one_cycle", 32'(bus.swap), 0);
        rd(15'd5, 16'hAAAA);

        // Second frame closes under r_lock: swap deferred
        wr(15'd7, 16'h1234);
        wr(15'd9, 16'h9999);
        bus.r_lock = 1'b1;
        eof();
        check("pend_swap",        32'(bus.swap), 0);
        check("pend_w_bank",      32'(bus.w_bank), 1);
        check("pend_frame_valid", 32'(bus.frame_valid), 1);
        check("pend_drop_cnt",    32'(bus.drop_cnt), 0);
        wr(15'd7, 16'h5555);
        check("pend_err_w", 32'(bus.err_w), 1);
        tick();
        check("pend_err_w_clear", 32'(bus.err_w), 0);
        rd(15'd5, 16'hAAAA);
        // Release lock with a write on the same edge: swap fires, write rejected
        bus.r_lock = 1'b0;
        wr(15'd9, 16'hBEEF);
        check("release_swap",   32'(bus.swap), 1);
        check("release_r_bank", 32'(bus.r_bank), 1);
        check("release_err_w",  32'(bus.err_w), 1);
        rd(15'd7, 16'h1234);
        rd(15'd9, 16'h9999);

        // Write and eof on the same edge: word lands in the closing bank 0
        bus.w_en = 1'b1; bus.w_addr = 15'd0; bus.d_in = 16'h0F0F;
        bus.w_eof = 1'b1;
        tick();
        idle_inputs();
        check("same_swap",   32'(bus.swap), 1);
        check("same_r_bank", 32'(bus.r_bank), 0);
        check("same_err_w",  32'(bus.err_w), 0);
        rd(15'd0, 16'h0F0F);

        // Read on the swap edge sees the old bank, next read the new bank
        wr(15'd5, 16'h5A5A);
        bus.r_en = 1'b1; bus.r_addr = 15'd5; bus.w_eof = 1'b1;
        exp_q.push_back(16'hAAAA);
        tick();
        idle_inputs();
        check("edge_swap",   32'(bus.swap), 1);
        check("edge_r_bank", 32'(bus.r_bank), 1);
        rd(15'd5, 16'h5A5A);

        // Over-run: saturating drop counter
        bus.r_lock = 1'b1;
        eof();
        check("drop_enter_pending", 32'(bus.drop_cnt), 0);
        bus.w_eof = 1'b1;
        repeat (10) tick();
        check("drop_10", 32'(bus.drop_cnt), 10);
        repeat (245) tick();
        check("drop_255", 32'(bus.drop_cnt), 255);
        repeat (45) tick();
        bus.w_eof = 1'b0;
        check("drop_sat_300", 32'(bus.drop_cnt), 255);
        check("drop_no_swap_w_bank", 32'(bus.w_bank), 0);

        // Asynchronous reset mid-PENDING
        wr(15'd1, 16'h1111);
        check("pre_rst_err_w", 32'(bus.err_w), 1);
        rst = 1'b1;
        #2;
        check("arst_frame_valid", 32'(bus.frame_valid), 0);
        check("arst_drop_cnt",    32'(bus.drop_cnt), 0);
        check("arst_w_bank",      32'(bus.w_bank), 0);
        check("arst_r_bank",      32'(bus.r_bank), 1);
        check("arst_err_w",       32'(bus.err_w), 0);
        check("arst_swap",        32'(bus.swap), 0);
        check("arst_r_valid",     32'(bus.r_valid), 0);
        check("arst_d_out",       32'(bus.d_out), 0);
        bus.r_lock = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_frame_valid", 32'(bus.frame_valid), 0);

        check("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/frame_pingpong_buffer.md
# frame_pingpong_buffer

Single-clock, parametrised double-buffered (ping-pong) frame store between the camera capture path and the display/processing read path. The writer fills one bank while the reader scans the other completed bank. Banks swap only at writer end-of-frame, and only when the reader is not holding a frame lock. Over-runs are flagged and counted, so the reader never sees a torn frame.

## Interface
- DATA_W, 16, pixel word width
- ADDR_W, 15, per-bank address width; bank depth = 2^ADDR_W (150x150 frame fits)
- DROP_W, 8, width of saturating dropped-frame counter

- clk  in  1  sole clock; all logic on posedge
- rst  in  1  asynchronous, active-high reset
- w_en  in  1  write strobe
- w_addr  in  ADDR_W  write address within write bank
- d_in  in  DATA_W  write data
- w_eof  in  1  one-cycle pulse: current write bank holds a complete frame
- r_en  in  1  read strobe
- r_addr  in  ADDR_W  read address within read bank
- r_lock  in  1  high while reader is mid-frame; defers swaps
- d_out  out  DATA_W  registered read data
- r_valid  out  1  d_out valid this cycle
- frame_valid  out  1  read bank holds a completed frame
- w_bank  out  1  bank currently written
- r_bank  out  1  bank currently read; always ~w_bank
- swap  out  1  one-cycle pulse on a bank swap
- err_w  out  1  registered: previous-cycle write rejected
- drop_cnt  out  DROP_W  frames lost to over-run, saturating

## Operation
- Storage: 2 x 2^ADDR_W x DATA_W array. Physical address is {bank, addr}. Not reset; contents undefined after reset.
- Reader and writer are always in opposite banks, so there is no same-address read/write collision.
- FSM states:
  - EMPTY: no completed frame yet
  - SHOW: read bank complete, writer filling the other bank
  - PENDING: write bank complete, swap deferred
- EMPTY, w_eof & !r_lock: swap, go to SHOW.
- EMPTY, w_eof & r_lock: go to PENDING.
- SHOW, w_eof & !r_lock: swap, stay in SHOW.
- SHOW, w_eof & r_lock: go to PENDING.
- PENDING, !r_lock: swap, go to SHOW. Evaluated every cycle, regardless of w_eof.
- Swap: w_bank and r_bank toggle; swap=1 for exactly that cycle.
- Writes in EMPTY/SHOW land in w_bank; err_w<=0.
- Writes in PENDING are rejected and memory is unchanged; err_w<=1. err_w<=0 on any cycle without w_en.
- w_eof in PENDING does not swap. drop_cnt increments, saturating at 2^DROP_W-1.
- Same cycle w_en & w_eof in EMPTY/SHOW: the write lands in the current bank before the frame closes.
- All decisions use state and bank values sampled at the clock edge. A write in PENDING on the cycle the deferred swap fires is still rejected.
- frame_valid = (state != EMPTY); registered with the state.
- Read: d_out <= mem[{r_bank, r_addr}] when r_en; r_valid <= r_en. d_out holds its last value when r_en=0.
- Reads in EMPTY are permitted; data is undefined and frame_valid=0.

## Timing
- Reset values: state=EMPTY, w_bank=0, r_bank=1, d_out=0, r_valid=0, frame_valid=0, swap=0, err_w=0, drop_cnt=0.
- Reset mid-frame discards all bank status immediately (asynchronous).
- Read latency 1 cycle: r_en at edge N gives d_out/r_valid valid after edge N.
- A read issued on a swap edge returns data from the pre-swap r_bank.
- Write latency 1 cycle. A read of the same bank/address is possible only after a swap.
- Swap is visible on w_bank/r_bank/swap after the edge that samples w_eof (or !r_lock in PENDING).
- No combinational input-to-output paths.

## Test plan
- Reset, write 0xAAAA at addr 5, pulse w_eof with r_lock=0 -> swap=1, w_bank=1, r_bank=0, frame_valid=1; read addr 5 -> d_out=0xAAAA one cycle later with r_valid=1.
- Fill bank 1 with 0x1234 at addr 7, pulse w_eof with r_lock=1 -> no swap, PENDING; next w_en -> err_w=1 and memory unchanged; drop r_lock -> swap next edge, r_bank=1, read addr 7 -> 0x1234.
- In PENDING, pulse w_eof 300 times with DROP_W=8 -> drop_cnt saturates at 255; reset -> drop_cnt=0.
- w_en and w_eof in same cycle (d_in=0x0F0F, addr 0, r_lock=0) -> word stored in old write bank; after swap, read addr 0 -> 0x0F0F.
- Read on the swap edge -> returns old-bank data. Read on the following cycle -> returns new-bank data.
- Assert rst asynchronously mid-PENDING -> outputs go to reset values without a clock edge; frame_valid=0.
